// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block sequencer: state encoding and block geometry.
package sha256_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_COLLECT = 3'd1;
  localparam state_t ST_ROUNDS  = 3'd2;
  localparam state_t ST_FINAL   = 3'd3;
  localparam state_t ST_DIGEST  = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam int BLOCK_BYTES  = 64;
  localparam int BLOCK_WORDS  = 16;
  localparam int NUM_ROUNDS   = 64;
  localparam int DIGEST_BYTES = 32;

endpackage

// File: rtl/sha256_word_assembler.sv
// Packs a byte stream big-endian into 32-bit words and strobes each completed word
// into the core's W buffer one cycle after its fourth byte.
module sha256_word_assembler
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  in_byte,
  output logic        w_we,
  output logic [3:0]  w_idx,
  output logic [31:0] w_word,
  output logic        blk_done
);

  logic [5:0]  byte_cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      shreg    <= '0;
      w_we     <= 1'b0;
      w_idx    <= '0;
      w_word   <= '0;
      blk_done <= 1'b0;
    end else begin
      w_we     <= 1'b0;
      blk_done <= 1'b0;
      if (clr) begin
        byte_cnt <= '0;
        shreg    <= '0;
      end else if (byte_en) begin
        shreg    <= {shreg[15:0], in_byte};
        byte_cnt <= byte_cnt + 6'd1;
        // shreg holds the three earlier bytes, so the word completes on this byte
        if (byte_cnt[1:0] == 2'd3) begin
          w_we   <= 1'b1;
          w_idx  <= byte_cnt[5:2];
          w_word <= {shreg, in_byte};
        end
        if (byte_cnt == 6'(BLOCK_BYTES - 1))
          blk_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Collects a padded 64-byte block, sequences the SHA-256 core through 64 rounds and the
// final add, then streams the digest out. Optional collection timeout: SHA_SEQ_TIMEOUT_EN.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        core_init,
  output logic        core_w_we,
  output logic [3:0]  core_w_idx,
  output logic [31:0] core_w_word,
  output logic        core_round_en,
  output logic [5:0]  core_round_idx,
  output logic        core_final_add,
  output logic [4:0]  core_digest_sel,
  input  logic [7:0]  core_digest_byte,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        ovf_err
);

  if ((64'd1 << TIMEOUT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_err
    $error("TIMEOUT_W is too narrow to count TIMEOUT_CYCLES");
  end

  state_t     state, state_nxt;
  logic       blk_done, byte_en, asm_clr, timeout_abort, tx_hs;
  logic [5:0] round_cnt;
  logic [4:0] sel_cnt;

  // The cycle the last word is written, the block is complete; late bytes are overflow.
  assign byte_en = in_valid && ((state == ST_IDLE) || (state == ST_COLLECT && !blk_done));
  assign asm_clr = (state == ST_DONE) || timeout_abort;
  assign tx_hs   = (state == ST_DIGEST) && tx_ready;

  sha256_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (asm_clr),
    .byte_en  (byte_en),
    .in_byte  (in_byte),
    .w_we     (core_w_we),
    .w_idx    (core_w_idx),
    .w_word   (core_w_word),
    .blk_done (blk_done)
  );

`ifdef SHA_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      gap_cnt <= '0;
    else if (state != ST_COLLECT || in_valid)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + 1'b1;
  end

  assign timeout_abort = (state == ST_COLLECT) && !blk_done && !in_valid &&
                         (gap_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (in_valid) state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        if (blk_done)           state_nxt = ST_ROUNDS;
        else if (timeout_abort) state_nxt = ST_IDLE;
      end
      ST_ROUNDS:  if (round_cnt == 6'(NUM_ROUNDS - 1)) state_nxt = ST_FINAL;
      ST_FINAL:   state_nxt = ST_DIGEST;
      ST_DIGEST:  if (tx_hs && sel_cnt == 5'(DIGEST_BYTES - 1)) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    core_round_en  = (state == ST_ROUNDS);
    core_final_add = (state == ST_FINAL);
    tx_valid       = (state == ST_DIGEST);
    tx_byte        = (state == ST_DIGEST) ? core_digest_byte : 8'h00;
    busy           = (state != ST_IDLE);
  end

  assign core_round_idx  = round_cnt;
  assign core_digest_sel = sel_cnt;

  // Counters saturate at their last value and only clear in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_cnt <= '0;
      sel_cnt   <= '0;
      core_init <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      core_init <= (state == ST_IDLE) && in_valid;
      if (state == ST_DONE)
        round_cnt <= '0;
      else if (state == ST_ROUNDS && round_cnt != 6'(NUM_ROUNDS - 1))
        round_cnt <= round_cnt + 6'd1;
      if (state == ST_DONE)
        sel_cnt <= '0;
      else if (tx_hs && sel_cnt != 5'(DIGEST_BYTES - 1))
        sel_cnt <= sel_cnt + 5'd1;
      if (state == ST_IDLE && in_valid)
        ovf_err <= 1'b0;
      else if ((in_valid && !byte_en) || timeout_abort)
        ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer: the driver queues expected core/tx events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sha256_block_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        core_init, core_w_we, core_round_en, core_final_add;
  logic [3:0]  core_w_idx;
  logic [31:0] core_w_word;
  logic [5:0]  core_round_idx;
  logic [4:0]  core_digest_sel;
  logic [7:0]  core_digest_byte;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, ovf_err;

  sha256_block_sequencer #(.TIMEOUT_CYCLES(50), .TIMEOUT_W(17)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_byte          (in_byte),
    .in_valid         (in_valid),
    .core_init        (core_init),
    .core_w_we        (core_w_we),
    .core_w_idx       (core_w_idx),
    .core_w_word      (core_w_word),
    .core_round_en    (core_round_en),
    .core_round_idx   (core_round_idx),
    .core_final_add   (core_final_add),
    .core_digest_sel  (core_digest_sel),
    .core_digest_byte (core_digest_byte),
    .tx_byte          (tx_byte),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .busy             (busy),
    .ovf_err          (ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the compression core's digest mux: distinct byte per select.
  function automatic logic [7:0] dig_model(input int i);
    return 8'((i * 37 + 8'h5A) & 8'hFF);
  endfunction
  assign core_digest_byte = dig_model(int'(core_digest_sel));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [35:0] q_w[$];
  int          q_round[$];
  int          q_init[$];
  int          q_final[$];
  logic [12:0] q_tx[$];

  logic [31:0] w_seen[16];
  int n_init = 0, n_round = 0, n_final = 0, n_tx = 0;
  int first_round_cyc = -1;
  int last_byte_cyc = 0;

  initial begin : monitor
    logic [35:0] ew;
    logic [12:0] et;
    int          er;
    bit          stall_pend;
    logic [12:0] stall_val;
    stall_pend = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 1'b0;
      end else begin
        if (core_init) begin
          n_init++;
          check("init_expected", 64'(q_init.size() > 0), 64'd1);
          if (q_init.size() > 0) void'(q_init.pop_front());
        end
        if (core_w_we) begin
          w_seen[core_w_idx] = core_w_word;
          check("w_expected", 64'(q_w.size() > 0), 64'd1);
          if (q_w.size() > 0) begin
            ew = q_w.pop_front();
            check("w_idx_word", 64'({core_w_idx, core_w_word}), 64'(ew));
          end
        end
        if (core_round_en) begin
          n_round++;
          if (first_round_cyc < 0) first_round_cyc = cyc;
          check("round_expected", 64'(q_round.size() > 0), 64'd1);
          if (q_round.size() > 0) begin
            er = q_round.pop_front();
            check("round_idx", 64'(core_round_idx), 64'(er));
          end
        end
        if (core_final_add) begin
          n_final++;
          check("final_expected", 64'(q_final.size() > 0), 64'd1);
          if (q_final.size() > 0) void'(q_final.pop_front());
        end
        if (stall_pend) begin
          check("tx_valid_held", 64'(tx_valid), 64'd1);
          check("tx_stall_stable", 64'({core_digest_sel, tx_byte}), 64'(stall_val));
        end
        if (tx_valid && tx_ready) begin
          n_tx++;
          check("tx_expected", 64'(q_tx.size() > 0), 64'd1);
          if (q_tx.size() > 0) begin
            et = q_tx.pop_front();
            check("tx_sel_byte", 64'({core_digest_sel, tx_byte}), 64'(et));
          end
        end
        stall_pend = tx_valid && !tx_ready;
        stall_val  = {core_digest_sel, tx_byte};
      end
    end
  end

  // Drives n bytes base, base+1, ... on consecutive cycles, queueing what they should cause.
  task automatic send_bytes(input logic [7:0] base, input int n, input bit chk_ovf_clear);
    logic [23:0] sh;
    logic [7:0]  b;
    sh = '0;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + 8'(i));
      in_valid = 1'b1;
      in_byte  = b;
      if (i == 0) q_init.push_back(1);
      if (i % 4 == 3) q_w.push_back({4'(i / 4), sh, b});
      sh = {sh[15:0], b};
      if (i == 63) begin
        last_byte_cyc = cyc;
        for (int r = 0; r < 64; r++) q_round.push_back(r);
        q_final.push_back(1);
        for (int s = 0; s < 32; s++) q_tx.push_back({5'(s), dig_model(s)});
      end
      @(posedge clk); #1;
      if (chk_ovf_clear && i == 0) check("ovf_clear_on_start", 64'(ovf_err), 64'd0);
    end
    in_valid = 1'b0;
  endtask

  // Runs the block to IDLE; mode 1 toggles tx_ready 1,0,0,...; inject drives a byte at round 10.
  task automatic finish_block(input int mode, input bit inject);
    int k;
    bit inj;
    k = 0;
    inj = 1'b0;
    while (busy && k < 400) begin
      tx_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      if (inject && !inj && core_round_en && core_round_idx == 6'd10) begin
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        inj = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      k++;
    end
    tx_ready = 1'b1;
    check("block_returns_idle", 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({core_init, core_w_we, core_w_idx, core_w_word, core_round_en, core_round_idx,
                core_final_add, core_digest_sel, tx_byte, tx_valid, busy, ovf_err});
  endfunction

  initial begin : driver
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Block A: bytes 0x00..0x3F, ready always high
    first_round_cyc = -1; n_init = 0; n_round = 0; n_final = 0; n_tx = 0;
    send_bytes(8'h00, 64, 1'b0);
    finish_block(0, 1'b0);
    check("A_round_latency", 64'(first_round_cyc - last_byte_cyc), 64'd2);
    check("A_word0", 64'(w_seen[0]), 64'h0001_0203);
    check("A_word15", 64'(w_seen[15]), 64'h3C3D_3E3F);
    check("A_init_once", 64'(n_init), 64'd1);
    check("A_rounds", 64'(n_round), 64'd64);
    check("A_final_once", 64'(n_final), 64'd1);
    check("A_tx_count", 64'(n_tx), 64'd32);
    check("A_ovf", 64'(ovf_err), 64'd0);

    // Block B: toggling ready, stray byte at round 10
    n_round = 0; n_tx = 0;
    send_bytes(8'h40, 64, 1'b0);
    finish_block(1, 1'b1);
    check("B_rounds", 64'(n_round), 64'd64);
    check("B_tx_count", 64'(n_tx), 64'd32);
    check("B_ovf_set", 64'(ovf_err), 64'd1);

    // Block C: reset after byte 30
    send_bytes(8'h80, 31, 1'b1);
    #2 rst = 1'b1;
    #1 check("C_async_reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Block D: full block after the aborted one
    first_round_cyc = -1; n_init = 0; n_round = 0;
    send_bytes(8'hC0, 64, 1'b0);
    finish_block(0, 1'b0);
    check("D_init_once", 64'(n_init), 64'd1);
    check("D_round_latency", 64'(first_round_cyc - last_byte_cyc), 64'd2);
    check("D_word0", 64'(w_seen[0]), 64'hC0C1_C2C3);
    check("D_rounds", 64'(n_round), 64'd64);

    // Block E: stall after 20 bytes
    n_round = 0;
    send_bytes(8'h10, 20, 1'b0);
    repeat (60) @(posedge clk);
    #1;
`ifdef SHA_SEQ_TIMEOUT_EN
    check("E_timeout_idle", 64'(busy), 64'd0);
    check("E_timeout_ovf", 64'(ovf_err), 64'd1);
`else
    check("E_waits_in_collect", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    check("E_no_rounds", 64'(n_round), 64'd0);

    check("q_init_empty", 64'(q_init.size()), 64'd0);
    check("q_w_empty", 64'(q_w.size()), 64'd0);
    check("q_round_empty", 64'(q_round.size()), 64'd0);
    check("q_final_empty", 64'(q_final.size()), 64'd0);
    check("q_tx_empty", 64'(q_tx.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
- Controller between the byte-stream message packer and the SHA-256 compression datapath.
- Collects one padded 64-byte block and packs it big-endian into 16 32-bit words, writing each word into the core's W buffer.
- Then sequences the core: 64 round strobes, followed by the final hash addition.
- Finally streams the 32-byte digest out to the UART transmitter under a valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 100000: maximum allowed cycle gap between input bytes during collection. Used only with SHA_SEQ_TIMEOUT_EN.
- TIMEOUT_W, 17: width of the timeout counter. Must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_byte  in  8  padded block byte from the packer
- in_valid  in  1  in_byte valid; one byte per high cycle; no backpressure
- core_init  out  1  one-cycle pulse: load H0..H7 initial values into the core
- core_w_we  out  1  one-cycle pulse: write core_w_word at core_w_idx
- core_w_idx  out  4  word index 0..15
- core_w_word  out  32  packed word, first byte received in [31:24]
- core_round_en  out  1  high one cycle per compression round
- core_round_idx  out  6  current round 0..63, valid while core_round_en is high
- core_final_add  out  1  one-cycle pulse: H += a..h
- core_digest_sel  out  5  digest byte select 0..31, byte 0 = H0[31:24]
- core_digest_byte  in  8  combinational digest byte for core_digest_sel
- tx_byte  out  8  digest byte to the UART transmitter
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- ovf_err  out  1  sticky: a byte arrived outside COLLECT

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; ovf_err 0.
- States: IDLE, COLLECT, ROUNDS, FINAL, DIGEST, DONE.
- IDLE:
  - On in_valid: core_init pulses the same cycle as the registered transition to COLLECT.
  - That first byte is captured as byte 0 of the block. It is not dropped.
  - ovf_err clears on this event.
- COLLECT:
  - Each accepted byte shifts into a 32-bit shift register; the byte counter increments (6 bits).
  - On every 4th byte: core_w_we pulses the following cycle, with core_w_idx = byte_cnt[5:2] and the full word.
  - After byte 63: the word-15 write is issued, then the next cycle enters ROUNDS.
  - Latency from last input byte to the first core_round_en is 2 cycles.
- ROUNDS:
  - core_round_en is high for exactly 64 consecutive cycles; core_round_idx = 0..63.
  - After round 63, go to FINAL.
- FINAL: core_final_add pulses for 1 cycle, then go to DIGEST with core_digest_sel = 0.
- DIGEST:
  - tx_valid = 1; tx_byte = core_digest_byte.
  - tx_byte and core_digest_sel are held stable while tx_ready = 0.
  - On each handshake, sel increments. After the handshake at sel = 31, go to DONE.
  - tx_valid must not be deasserted without a handshake.
- DONE: 1 cycle, all counters cleared, then IDLE.
- Bytes arriving in ROUNDS, FINAL, DIGEST or DONE are dropped and set ovf_err. The sequence is unaffected.
- Simultaneous events:
  - in_valid in the same cycle as DONE→IDLE is dropped and sets ovf_err.
  - A block can start only from IDLE.
- Reset mid-operation:
  - Immediate return to IDLE; all strobes deassert asynchronously.
  - Partial block contents are discarded, and the core is not notified.
- Counters never wrap inside a state: round_idx stops at 63, digest_sel stops at 31.

Optional Feature:
- Macro: SHA_SEQ_TIMEOUT_EN.
- Enabled:
  - In COLLECT, a gap counter resets on each in_valid and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, the block is aborted: go to IDLE, counters cleared, no further core_w_we, and ovf_err is set.
  - The next in_valid starts a fresh block with core_init.
- Disabled: no gap counter exists; COLLECT waits indefinitely.

Decomposition:
- Shared package sha256_pkg holds:
  - state encoding localparams
  - BLOCK_BYTES = 64, BLOCK_WORDS = 16, NUM_ROUNDS = 64, DIGEST_BYTES = 32
- Natural sub-module: sha256_word_assembler, a byte-to-32-bit shift register with byte counter and word-write strobe generation. The FSM, round counter and digest streaming stay in the top level.

Test Plan:
- Reset, then 64 bytes 0x00..0x3F on consecutive cycles:
  - 16 core_w_we pulses; idx 0 word = 0x00010203, idx 15 word = 0x3C3D3E3F.
  - core_init exactly once.
  - First core_round_en 2 cycles after the last byte; 64 rounds, idx 0..63; one core_final_add.
- DIGEST with tx_ready held 1:
  - 32 tx handshakes on consecutive cycles; tx_byte equals core model bytes, sel 0..31; then DONE, IDLE, busy = 0.
- DIGEST with tx_ready toggling 1,0,0,1...:
  - tx_byte and sel stay stable during stalls; exactly 32 bytes transferred, none duplicated.
- Inject in_valid at round 10:
  - ovf_err = 1; round sequence unchanged.
  - Next block start clears ovf_err.
- Assert rst at byte 30 of COLLECT:
  - All outputs 0 asynchronously.
  - A subsequent full 64-byte block completes normally, starting with core_init.
- With SHA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 50, stop after 20 bytes:
  - Abort at cycle 50 of the gap; ovf_err = 1; no core_round_en.
  - Without the macro, the block stays in COLLECT.
